ps2_rx_fifo: RTL

Parametrised PS/2 device-to-host receiver. It replaces the single-register keyboard capture with four additions:
- glitch-filtered falling-edge detection
- full 11-bit frame checking (start, odd parity, stop) with a frame timeout
- optional E0/F0 prefix decoding
- a show-ahead FIFO of decoded key events read by downstream logic

It is receive-only and sits between the PS/2 pins and the key-handling logic. It never drives the PS/2 clock line.

---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_edge_filter.sv | 42 ++++
 rtl/ps2_rx_fifo.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 receive path
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  // Event entry layout: {ext, rel, code[7:0]}
  localparam int PS2_EVT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } rx_state_e;

endpackage

// File: rtl/ps2_edge_filter.sv
// rtl/ps2_edge_filter.sv - synchroniser plus level filter producing a falling-edge strobe
module ps2_edge_filter #(
  parameter int FILTER_LEN = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // The level flips on the FILTER_LEN-th consecutive sample that disagrees with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_q <= sync_q[1];
        fall_q  <= level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 frame receiver with prefix decoding and a show-ahead event FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 6,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  input  logic                        rd_en,
  output logic [7:0]                  rd_code,
  output logic                        rd_ext,
  output logic                        rd_rel,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic       fall;
  logic [1:0] data_sync_q;
  logic       data_s;

  ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .reset  (reset),
    .pin_i  (ps2_clk),
    .fall_o (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_sync_q <= 2'b11;
    else       data_sync_q <= {data_sync_q[0], ps2_data};
  end
  assign data_s = data_sync_q[1];

  rx_state_e      state_q;
  logic [3:0]     bit_cnt_q;
  logic [9:0]     shreg_q;
  logic [TW-1:0]  timer_q;
  logic           ext_q, rel_q;
  logic           parity_err_q, frame_err_q;

  logic           stop_ok, par_ok, is_prefix, push_w;
  logic [PS2_EVT_W-1:0] push_entry;

  // shreg_q holds {stop, parity, data[7:0]} once all ten post-start bits are in.
  always_comb begin
    stop_ok    = shreg_q[9];
    par_ok     = ^shreg_q[8:0];
    is_prefix  = (DECODE_PREFIX != 0) &&
                 (shreg_q[7:0] == PS2_PREFIX_EXT || shreg_q[7:0] == PS2_PREFIX_BREAK);
    push_w     = (state_q == CHECK) && stop_ok && par_ok && !is_prefix;
    push_entry = {ext_q, rel_q, shreg_q[7:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      timer_q      <= '0;
      ext_q        <= 1'b0;
      rel_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall && !data_s) begin
            state_q   <= SHIFT;
            bit_cnt_q <= 4'd1;
            timer_q   <= '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            shreg_q   <= {data_s, shreg_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            timer_q   <= '0;
            if (bit_cnt_q == 4'd10) state_q <= CHECK;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            state_q     <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        CHECK: begin
          state_q <= IDLE;
          if (!stop_ok) begin
            frame_err_q <= 1'b1;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
          end else if (!par_ok) begin
            parity_err_q <= 1'b1;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
          end else if (DECODE_PREFIX != 0 && shreg_q[7:0] == PS2_PREFIX_EXT) begin
            ext_q <= 1'b1;
          end else if (DECODE_PREFIX != 0 && shreg_q[7:0] == PS2_PREFIX_BREAK) begin
            rel_q <= 1'b1;
          end else begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [PS2_EVT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q;
  logic                 pop, full_w, wr_ok;
  logic [PS2_EVT_W-1:0] head_w;

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    full_w  = (count_q == CW'(FIFO_DEPTH));
    pop     = rd_en && (count_q != '0);
    wr_ok   = push_w && (!full_w || pop);
    count_d = count_q;
    if (wr_ok && !pop)      count_d = count_q + CW'(1);
    else if (!wr_ok && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      overflow_q <= push_w && !wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_w     = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign full       = full_w;
  assign count      = count_q;
  assign rd_code    = empty ? 8'h00 : head_w[7:0];
  assign rd_ext     = !empty && head_w[9];
  assign rd_rel     = !empty && head_w[8];
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
